// File: rtl/alu_lp_pkg.sv
// alu_lp_pkg: shared opcodes, command layout and dispatcher state encoding
// for the low-power 16-bit ALU and its issue stage.
package alu_lp_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_MUL = 3'b111;

    // Packed command word {op, a, b}
    localparam int CMD_W = 35;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } alu_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } disp_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO. The ready flag is registered from
// next-state occupancy so it is 0 in reset and never rises on a same-cycle pop.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         ready_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != FULL_CNT);
    assign do_pop  = pop_i && (cnt_q != '0);
    assign empty_o = (cnt_q == '0);
    assign ready_o = ready_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next occupancy from accepted push/pop
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != FULL_CNT);
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// alu_cmd_dispatcher: buffers ALU commands, drives the gated ALU only while a
// command is in flight, captures its result, and counts gated cycles.
module alu_cmd_dispatcher
    import alu_lp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_enable,
    input  logic [15:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             busy,
    output logic [CNT_W-1:0] gated_cycles
);
    disp_state_e      state_q;
    logic [2:0]       lat_q;
    logic [15:0]      alu_a_q, alu_b_q, rsp_result_q;
    logic [2:0]       alu_op_q;
    logic             alu_en_q, rsp_valid_q, rsp_zero_q, rsp_carry_q;
    logic [CNT_W-1:0] gated_q, gated_d;
    alu_cmd_t         wr_cmd, head;
    logic [CMD_W-1:0] head_raw;
    logic             fifo_empty, fifo_push, fifo_pop, rsp_fire;

    assign wr_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign head      = alu_cmd_t'(head_raw);
    assign fifo_push = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid_q && rsp_ready;
    // The head is popped on the edge that loads it into the ALU registers
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == ST_IDLE) || (state_q == ST_RESP && rsp_fire));

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wr_cmd),
        .rdata_o (head_raw),
        .empty_o (fifo_empty),
        .ready_o (cmd_ready)
    );

    // Issue FSM; outputs are set on the edge entering a state, so ISSUE is
    // the first cycle the ALU sees enable and its operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lat_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_en_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a_q  <= head.a;
                        alu_b_q  <= head.b;
                        alu_op_q <= head.op;
                        alu_en_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ALU_LAT > 1) begin
                        lat_q   <= 3'd2;
                        state_q <= ST_WAIT;
                    end else begin
                        alu_en_q <= 1'b0;
                        state_q  <= ST_CAPT;
                    end
                end
                ST_WAIT: begin
                    // lat_q counts enabled cycles including the current one
                    if (lat_q == 3'(ALU_LAT)) begin
                        alu_en_q <= 1'b0;
                        state_q  <= ST_CAPT;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                ST_CAPT: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp_carry_q  <= alu_carry;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            alu_a_q  <= head.a;
                            alu_b_q  <= head.b;
                            alu_op_q <= head.op;
                            alu_en_q <= 1'b1;
                            state_q  <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gated-cycle counter saturates at all-ones
    always_comb begin
        gated_d = gated_q;
        if (!alu_en_q && !(&gated_q)) gated_d = gated_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gated_q <= '0;
        else        gated_q <= gated_d;
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_enable   = alu_en_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign busy         = !fifo_empty || (state_q != ST_IDLE);
    assign gated_cycles = gated_q;

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Bench for alu_cmd_dispatcher: one instance at ALU_LAT=1/CNT_W=32 and one at
// ALU_LAT=3/CNT_W=4, each fed by a behavioural ALU.
module tb_alu_cmd_dispatcher;
    import alu_lp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance 1: ALU_LAT=1
    logic        rst_n, c_valid, c_ready, a_en, r_valid, r_ready, r_z, r_c, bsy;
    logic [15:0] c_a, c_b, a_a, a_b, r_res;
    logic [2:0]  c_op, a_op;
    logic [15:0] a_res = '0;
    logic        a_z = 1'b0, a_c = 1'b0;
    logic [31:0] gc;

    // Instance 2: ALU_LAT=3, 4-bit counter
    logic        rst2_n, c_valid2, c_ready2, a_en2, r_valid2, r_ready2, r_z2, r_c2, bsy2;
    logic [15:0] c_a2, c_b2, a_a2, a_b2, r_res2;
    logic [2:0]  c_op2, a_op2;
    logic [15:0] a_res2 = '0;
    logic        a_z2 = 1'b0, a_c2 = 1'b0;
    logic [3:0]  gc2;

    alu_cmd_dispatcher #(.DEPTH(4), .ALU_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_a(c_a), .cmd_b(c_b), .cmd_op(c_op), .alu_a(a_a), .alu_b(a_b),
        .alu_op(a_op), .alu_enable(a_en), .alu_result(a_res), .alu_zero(a_z),
        .alu_carry(a_c), .rsp_valid(r_valid), .rsp_ready(r_ready),
        .rsp_result(r_res), .rsp_zero(r_z), .rsp_carry(r_c), .busy(bsy),
        .gated_cycles(gc));

    alu_cmd_dispatcher #(.DEPTH(4), .ALU_LAT(3), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .cmd_valid(c_valid2), .cmd_ready(c_ready2),
        .cmd_a(c_a2), .cmd_b(c_b2), .cmd_op(c_op2), .alu_a(a_a2), .alu_b(a_b2),
        .alu_op(a_op2), .alu_enable(a_en2), .alu_result(a_res2), .alu_zero(a_z2),
        .alu_carry(a_c2), .rsp_valid(r_valid2), .rsp_ready(r_ready2),
        .rsp_result(r_res2), .rsp_zero(r_z2), .rsp_carry(r_c2), .busy(bsy2),
        .gated_cycles(gc2));

    // Behavioural ALU: returns {zero, carry, result}
    function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [31:0] m;
        m = 32'(a) * 32'(b);
        case (op)
            ALU_OP_ADD: w = {1'b0, a} + {1'b0, b};
            ALU_OP_SUB: w = {1'b0, a} - {1'b0, b};
            ALU_OP_AND: w = {1'b0, a & b};
            ALU_OP_MUL: w = {|m[31:16], m[15:0]};
            default:    w = {1'b0, a ^ b};
        endcase
        return {(w[15:0] == 16'd0), w[16], w[15:0]};
    endfunction

    // The ALUs update their outputs on every enabled edge
    always @(posedge clk) if (a_en)  {a_z, a_c, a_res}    <= alu_f(a_op, a_a, a_b);
    always @(posedge clk) if (a_en2) {a_z2, a_c2, a_res2} <= alu_f(a_op2, a_a2, a_b2);

    // Scoreboard for instance 1: expected responses in acceptance order
    logic [17:0] exp_q[$];
    logic [17:0] rsp_log[$];
    int          en_rises = 0;
    logic        en_prev = 1'b0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (c_valid && c_ready) exp_q.push_back(alu_f(c_op, c_a, c_b));
            if (r_valid && r_ready) rsp_log.push_back({r_z, r_c, r_res});
            if (a_en && !en_prev) en_rises++;
        end
        en_prev = a_en;
    end

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        c_valid = 1'b0; c_a = '0; c_b = '0; c_op = '0; r_ready = 1'b0;
        c_valid2 = 1'b0; c_a2 = '0; c_b2 = '0; c_op2 = '0; r_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({c_ready, a_en, r_valid, bsy, r_z, r_c} !== 6'd0 || a_a !== 16'd0 || a_b !== 16'd0 ||
            a_op !== 3'd0 || r_res !== 16'd0 || gc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b en=%b rv=%b busy=%b a=%h b=%h op=%h res=%h gc=%0d, all required 0",
                     c_ready, a_en, r_valid, bsy, a_a, a_b, a_op, r_res, gc);
        end
        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        checks++;
        if (c_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", c_ready); end
        checks++;
        if (gc !== 32'd1) begin errors++; $display("FAIL reset_gc_first: got %0d want 1", gc); end
    endtask

    task automatic test_single_add();
        int en_cnt = 0;
        int vld_at = -1;
        logic [15:0] res = '0;
        logic z = 1'b1, c = 1'b1;
        r_ready = 1'b1;
        c_valid = 1'b1; c_op = ALU_OP_ADD; c_a = 16'd1000; c_b = 16'd500;
        @(negedge clk);
        c_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (a_en) en_cnt++;
            if (r_valid && vld_at < 0) begin vld_at = k; res = r_res; z = r_z; c = r_c; end
        end
        checks++;
        if (vld_at != 3) begin errors++; $display("FAIL add_latency: valid at N+%0d want N+3", vld_at); end
        checks++;
        if (res !== 16'd1500 || z !== 1'b0 || c !== 1'b0) begin
            errors++; $display("FAIL add_result: got %0d z=%b c=%b want 1500 z=0 c=0", res, z, c);
        end
        checks++;
        if (en_cnt != 1) begin errors++; $display("FAIL add_enable_cycles: got %0d want 1", en_cnt); end
        checks++;
        if (bsy !== 1'b0 || r_valid !== 1'b0) begin
            errors++; $display("FAIL add_done: busy=%b rsp_valid=%b want 0 0", bsy, r_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{ALU_OP_SUB, ALU_OP_AND, ALU_OP_MUL};
        logic [15:0] as  [3] = '{16'd1000, 16'hFF00, 16'd100};
        logic [15:0] bs  [3] = '{16'd300, 16'h0FF0, 16'd200};
        logic [15:0] want[3] = '{16'd700, 16'h0F00, 16'd20000};
        int b0 = rsp_log.size();
        int r0 = en_rises;
        r_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (c_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, c_ready); end
            c_valid = 1'b1; c_op = ops[i]; c_a = as[i]; c_b = bs[i];
            @(negedge clk);
        end
        c_valid = 1'b0;
        for (int t = 0; t < 40 && rsp_log.size() - b0 < 3; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_log.size() - b0 != 3) begin
            errors++; $display("FAIL b2b_count: got %0d want 3", rsp_log.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rsp_log[b0+i][15:0] !== want[i]) begin
                    errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, rsp_log[b0+i][15:0], want[i]);
                end
            end
        end
        checks++;
        if (en_rises - r0 != 3) begin errors++; $display("FAIL b2b_enable_pulses: got %0d want 3", en_rises - r0); end
    endtask

    task automatic test_fill();
        int b0 = rsp_log.size();
        int e0 = exp_q.size();
        r_ready = 1'b0;
        c_valid = 1'b1; c_op = 3'($urandom_range(0, 7)); c_a = 16'($urandom); c_b = 16'($urandom);
        @(negedge clk);
        c_valid = 1'b0;
        for (int t = 0; t < 10 && !r_valid; t++) @(negedge clk);
        // Dispatcher now stalled holding one response; fill the FIFO
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, c_ready); end
            c_valid = 1'b1; c_op = 3'($urandom_range(0, 7)); c_a = 16'($urandom); c_b = 16'($urandom);
            @(negedge clk);
        end
        checks++;
        if (c_ready !== 1'b0) begin errors++; $display("FAIL fill_full: cmd_ready got %b want 0", c_ready); end
        c_op = ALU_OP_ADD; c_a = 16'hDEAD; c_b = 16'h0001;
        repeat (3) @(negedge clk);
        c_valid = 1'b0;
        checks++;
        if (exp_q.size() - e0 != 5 || c_ready !== 1'b0 || bsy !== 1'b1) begin
            errors++; $display("FAIL fill_accepted: got %0d ready=%b busy=%b want 5 0 1", exp_q.size() - e0, c_ready, bsy);
        end
        r_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (c_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %b want 1", c_ready); end
        for (int t = 0; t < 60 && rsp_log.size() - b0 < 5; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_log.size() - b0 != 5) begin
            errors++; $display("FAIL fill_rsp_count: got %0d want 5", rsp_log.size() - b0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rsp_log[b0+i] !== exp_q[e0+i]) begin
                    errors++; $display("FAIL fill_rsp[%0d]: got %h want %h", i, rsp_log[b0+i], exp_q[e0+i]);
                end
            end
        end
    endtask

    task automatic test_idle();
        logic [15:0] sa = a_a, sb = a_b;
        logic [2:0]  so = a_op;
        logic [31:0] sg = gc;
        c_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            c_a = 16'($urandom); c_b = 16'($urandom); c_op = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        checks++;
        if (a_a !== sa || a_b !== sb || a_op !== so || a_en !== 1'b0) begin
            errors++; $display("FAIL idle_hold: a=%h b=%h op=%h en=%b want %h %h %h 0", a_a, a_b, a_op, a_en, sa, sb, so);
        end
        checks++;
        if (gc !== sg + 32'd10) begin errors++; $display("FAIL idle_gated: got %0d want %0d", gc, sg + 32'd10); end
    endtask

    task automatic test_zero();
        int b0 = rsp_log.size();
        r_ready = 1'b1;
        c_valid = 1'b1; c_op = ALU_OP_SUB; c_a = 16'd5; c_b = 16'd5;
        @(negedge clk);
        c_valid = 1'b0;
        for (int t = 0; t < 10 && rsp_log.size() == b0; t++) @(negedge clk);
        checks++;
        if (rsp_log.size() == b0) begin
            errors++; $display("FAIL zero_timeout: no response, want one");
        end else if (rsp_log[b0] !== {1'b1, 1'b0, 16'd0}) begin
            errors++; $display("FAIL zero_result: got z=%b c=%b res=%h want z=1 c=0 res=0",
                               rsp_log[b0][17], rsp_log[b0][16], rsp_log[b0][15:0]);
        end
    endtask

    task automatic test_random();
        int b0 = rsp_log.size();
        int e0 = exp_q.size();
        for (int i = 0; i < 300; i++) begin
            c_valid = 1'($urandom_range(0, 1));
            c_op    = 3'($urandom_range(0, 7));
            c_a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            c_b     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            r_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        c_valid = 1'b0; r_ready = 1'b1;
        for (int t = 0; t < 400 && (bsy || rsp_log.size() - b0 < exp_q.size() - e0); t++) @(negedge clk);
        checks++;
        if (rsp_log.size() - b0 != exp_q.size() - e0 || bsy !== 1'b0) begin
            errors++; $display("FAIL random_count: got %0d responses want %0d, busy=%b",
                               rsp_log.size() - b0, exp_q.size() - e0, bsy);
        end else begin
            for (int i = 0; i < rsp_log.size() - b0; i++) begin
                checks++;
                if (rsp_log[b0+i] !== exp_q[e0+i]) begin
                    errors++; $display("FAIL random_rsp[%0d]: got %h want %h", i, rsp_log[b0+i], exp_q[e0+i]);
                end
            end
        end
    endtask

    task automatic test_lat3();
        int en_cnt = 0;
        int vld_at = -1;
        logic [17:0] got = '0;
        r_ready2 = 1'b1;
        c_valid2 = 1'b1; c_op2 = ALU_OP_ADD; c_a2 = 16'hFFFF; c_b2 = 16'd2;
        @(negedge clk);
        c_valid2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (a_en2) en_cnt++;
            if (r_valid2 && vld_at < 0) begin vld_at = k; got = {r_z2, r_c2, r_res2}; end
        end
        checks++;
        if (vld_at != 5) begin errors++; $display("FAIL lat3_latency: valid at N+%0d want N+5", vld_at); end
        checks++;
        if (en_cnt != 3) begin errors++; $display("FAIL lat3_enable_cycles: got %0d want 3", en_cnt); end
        checks++;
        if (got !== {1'b0, 1'b1, 16'd1}) begin errors++; $display("FAIL lat3_result: got %h want %h", got, {1'b0, 1'b1, 16'd1}); end
    endtask

    task automatic test_reset_in_wait();
        bit saw_rsp = 0;
        r_ready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_valid2 = 1'b1; c_op2 = ALU_OP_ADD; c_a2 = 16'(i + 1); c_b2 = 16'd7;
            @(negedge clk);
        end
        c_valid2 = 1'b0;
        checks++;
        if (a_en2 !== 1'b1 || bsy2 !== 1'b1) begin
            errors++; $display("FAIL rstwait_pre: en=%b busy=%b want 1 1", a_en2, bsy2);
        end
        rst2_n = 1'b0;
        #1;
        checks++;
        if ({c_ready2, a_en2, r_valid2, bsy2, r_z2, r_c2} !== 6'd0 || a_a2 !== 16'd0 || a_b2 !== 16'd0 ||
            a_op2 !== 3'd0 || r_res2 !== 16'd0 || gc2 !== 4'd0) begin
            errors++; $display("FAIL rstwait_outputs: ready=%b en=%b rv=%b busy=%b a=%h gc=%0d, all required 0",
                               c_ready2, a_en2, r_valid2, bsy2, a_a2, gc2);
        end
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r_valid2 || a_en2) saw_rsp = 1;
        end
        checks++;
        if (saw_rsp || bsy2 !== 1'b0 || c_ready2 !== 1'b1) begin
            errors++; $display("FAIL rstwait_flush: activity=%0d busy=%b ready=%b want 0 0 1", saw_rsp, bsy2, c_ready2);
        end
    endtask

    task automatic test_saturate();
        int want;
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            want = (k > 15) ? 15 : k;
            checks++;
            if (gc2 !== 4'(want)) begin errors++; $display("FAIL saturate[%0d]: got %0d want %0d", k, gc2, want); end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_fill();
        test_idle();
        test_zero();
        test_random();
        test_idle();
        test_lat3();
        test_reset_in_wait();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
